// File: rtl/multicycle_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_pkg
// Shared definitions for the multi-cycle MIPS control FSM and its decoder:
// state encoding, opcode / funct (ALU code) constants, ALU operand-source
// encodings and the instruction-class enum latched in DECODE.
// -----------------------------------------------------------------------------
package multicycle_pkg;

    // State encoding is visible on the debug port, so values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEMRD  = 3'd4,
        ST_MEMWR  = 3'd5,
        ST_WB     = 3'd6,
        ST_HALT   = 3'd7
    } state_e;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // R-type funct values double as the ALU_Ctrl encoding of the existing ALU.
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;

    // ALU operand sources
    localparam logic       ALU_A_PC   = 1'b0;
    localparam logic       ALU_A_REG  = 1'b1;
    localparam logic [1:0] ALU_B_REG  = 2'b00;
    localparam logic [1:0] ALU_B_FOUR = 2'b01;
    localparam logic [1:0] ALU_B_IMM  = 2'b10;

    typedef enum logic [1:0] {
        CLS_LW,
        CLS_SW,
        CLS_ADDI,
        CLS_RTYPE
    } iclass_e;

    // States that hold a request on the unified memory port.
    function automatic logic is_req_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// -----------------------------------------------------------------------------
// mc_decode
// Purely combinational instruction classifier.
//   opcode_i   [5:0]  IR[31:26]
//   funct_i    [5:0]  IR[5:0]
//   class_o           instruction class (LW / SW / ADDI / RTYPE)
//   alu_code_o [5:0]  ALU function for the EXEC phase (funct for R-type)
//   legal_o           1 when the opcode/funct pair is supported
// -----------------------------------------------------------------------------
module mc_decode
    import multicycle_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output iclass_e    class_o,
    output logic [5:0] alu_code_o,
    output logic       legal_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        class_o    = CLS_RTYPE;
        alu_code_o = FN_ADD;
        legal_o    = 1'b0;
        case (opcode_i)
            OP_LW: begin
                class_o = CLS_LW;
                legal_o = 1'b1;
            end
            OP_SW: begin
                class_o = CLS_SW;
                legal_o = 1'b1;
            end
            OP_ADDI: begin
                class_o = CLS_ADDI;
                legal_o = 1'b1;
            end
            OP_RTYPE: begin
                class_o    = CLS_RTYPE;
                alu_code_o = funct_i;
                legal_o    = funct_i inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle MIPS controller: sequences one shared ALU and one unified memory
// port through FETCH / DECODE / EXEC / MEMRD / MEMWR / WB.
//   clk, rst (async, active high), run (start next instruction)
//   opcode, funct          instruction fields from IR
//   mem_ready              memory completes the current request this cycle
//   ALU_Ctrl, alu_src_a/b  ALU function and operand selects
//   iord, mem_req, mem_we  memory address source / request / write
//   ir_we, pc_we, reg_we   IR, PC and register-file write strobes
//   reg_dst, mem_to_reg    writeback destination / data source
//   halted, illegal, bus_err  sticky error status; state = debug view
// Parameters: TIMEOUT (mem_ready wait limit, 0 = none), CNT_W (counter width).
// Optional macro MULTICYCLE_CTRL_PERF_EN adds cycle_cnt / instret_cnt.
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic [5:0] ALU_Ctrl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       iord,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       halted,
    output logic       illegal,
    output logic       bus_err,
    output logic [2:0] state
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e            state_q, state_d;
    iclass_e           cls_q, cls_d;
    logic [5:0]        alu_code_q, alu_code_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;
    logic              complete;
    logic              timeout_hit;

    iclass_e    dec_class;
    logic [5:0] dec_alu_code;
    logic       dec_legal;

    mc_decode u_decode (
        .opcode_i   (opcode),
        .funct_i    (funct),
        .class_o    (dec_class),
        .alu_code_o (dec_alu_code),
        .legal_o    (dec_legal)
    );

    // The counter is zero on entry to every request state because every
    // path into one comes from a non-request state or a completed request.
    assign wait_d = (is_req_state(state_q) && !mem_ready) ? wait_q + 1'b1 : '0;

    // Only fires while mem_ready is low, so a late ready always wins.
    assign timeout_hit = (TIMEOUT != 0) && is_req_state(state_q) && !mem_ready
                         && (wait_q == WAIT_LAST);

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        alu_code_d = alu_code_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        complete   = 1'b0;
        ALU_Ctrl   = FN_ADD;
        alu_src_a  = ALU_A_PC;
        alu_src_b  = ALU_B_REG;
        iord       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // ALU computes PC+4 while memory returns the instruction.
                mem_req   = 1'b1;
                alu_src_b = ALU_B_FOUR;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
                if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                cls_d      = dec_class;
                alu_code_d = dec_alu_code;
                if (dec_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_EXEC: begin
                alu_src_a = ALU_A_REG;
                if (cls_q == CLS_RTYPE) begin
                    ALU_Ctrl = alu_code_q;
                end else begin
                    alu_src_b = ALU_B_IMM;
                end
                case (cls_q)
                    CLS_LW:  state_d = ST_MEMRD;
                    CLS_SW:  state_d = ST_MEMWR;
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = ST_WB;
            end
            ST_MEMWR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                iord     = 1'b1;
                complete = mem_ready;
            end
            ST_WB: begin
                reg_we     = 1'b1;
                reg_dst    = (cls_q == CLS_RTYPE);
                mem_to_reg = (cls_q == CLS_LW);
                complete   = 1'b1;
            end
            default: ;
        endcase

        // run is only consulted at an instruction boundary.
        if (complete) state_d = run ? ST_FETCH : ST_IDLE;

        if (timeout_hit) begin
            bus_err_d = 1'b1;
            state_d   = ST_HALT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cls_q      <= CLS_RTYPE;
            alu_code_q <= FN_ADD;
            wait_q     <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q    <= state_d;
            cls_q      <= cls_d;
            alu_code_q <= alu_code_d;
            wait_q     <= wait_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign halted  = illegal_q | bus_err_q;
    assign state   = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            if (state_q != ST_IDLE && state_q != ST_HALT) cycle_cnt_q <= cycle_cnt_q + 1'b1;
            if (complete) instret_cnt_q <= instret_cnt_q + 1'b1;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl. A phase-plan model of the instruction
// flow predicts every output each cycle; literal expectations pin key points.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int unsigned TIMEOUT = 16;
`ifdef MULTICYCLE_CTRL_PERF_EN
    localparam int unsigned CNT_W = 32;
`endif

    localparam int K_LW = 0, K_SW = 1, K_ADDI = 2, K_R = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       mem_ready = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h20;
    logic [5:0] op_s = 6'h00;
    logic [5:0] fn_s = 6'h20;

    logic [5:0] ALU_Ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord, mem_req, mem_we, ir_we, pc_we, reg_we, reg_dst, mem_to_reg;
    logic       halted, illegal, bus_err;
    logic [2:0] state;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .TIMEOUT(TIMEOUT)
`ifdef MULTICYCLE_CTRL_PERF_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .opcode     (opcode),
        .funct      (funct),
        .mem_ready  (mem_ready),
        .ALU_Ctrl   (ALU_Ctrl),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .iord       (iord),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .halted     (halted),
        .illegal    (illegal),
        .bus_err    (bus_err),
        .state      (state)
`ifdef MULTICYCLE_CTRL_PERF_EN
        , .cycle_cnt  (cycle_cnt)
        , .instret_cnt(instret_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int         m_state, m_kind, m_wait, m_cycles, m_inst;
    logic [5:0] m_code;
    bit         m_illegal, m_bus;
    int         plan[$];

    task automatic model_reset();
        m_state = 0; m_kind = K_R; m_wait = 0; m_cycles = 0; m_inst = 0;
        m_code = 6'h20; m_illegal = 0; m_bus = 0;
        plan.delete();
    endtask

    task automatic classify(input logic [5:0] op, input logic [5:0] fn,
                            output int kind, output logic [5:0] code, output bit ok);
        kind = K_R; code = 6'h20; ok = 0;
        if (op == 6'h23) begin kind = K_LW; ok = 1; end
        else if (op == 6'h2b) begin kind = K_SW; ok = 1; end
        else if (op == 6'h08) begin kind = K_ADDI; ok = 1; end
        else if (op == 6'h00) begin
            kind = K_R; code = fn;
            ok = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) ||
                 (fn == 6'h25) || (fn == 6'h26) || (fn == 6'h27);
        end
    endtask

    // Advance one clock: IDLE waits for run, request phases wait for
    // mem_ready (with timeout), the rest walk the instruction's phase plan.
    task automatic model_step();
        bit ok;
        bit is_req;
        is_req = (m_state == 1) || (m_state == 4) || (m_state == 5);
        if (m_state == 0) begin
            m_wait = 0;
            if (run) m_state = 1;
        end else if (m_state != 7) begin
            m_cycles++;
            if (is_req && !mem_ready) begin
                if (TIMEOUT != 0 && m_wait == int'(TIMEOUT) - 1) begin
                    m_bus = 1; m_state = 7;
                end else begin
                    m_wait++;
                end
            end else begin
                m_wait = 0;
                if (m_state == 1) begin
                    m_state = 2;
                end else if (m_state == 2) begin
                    classify(opcode, funct, m_kind, m_code, ok);
                    if (!ok) begin
                        m_illegal = 1; m_state = 7;
                    end else begin
                        plan.delete();
                        plan.push_back(3);
                        if (m_kind == K_LW) begin plan.push_back(4); plan.push_back(6); end
                        else if (m_kind == K_SW) plan.push_back(5);
                        else plan.push_back(6);
                        m_state = plan.pop_front();
                    end
                end else if (plan.size() != 0) begin
                    m_state = plan.pop_front();
                end else begin
                    m_inst++;
                    m_state = run ? 1 : 0;
                end
            end
        end
    endtask

    function automatic logic [22:0] expected_outputs();
        logic [5:0] alu;
        logic a, iord_e, req, we, irw, pcw, rwe, dst, m2r;
        logic [1:0] b;
        alu = 6'h20; a = 0; b = 2'b00;
        iord_e = 0; req = 0; we = 0; irw = 0; pcw = 0; rwe = 0; dst = 0; m2r = 0;
        case (m_state)
            1: begin req = 1; b = 2'b01; irw = mem_ready; pcw = mem_ready; end
            3: begin a = 1; if (m_kind == K_R) alu = m_code; else b = 2'b10; end
            4: begin req = 1; iord_e = 1; end
            5: begin req = 1; iord_e = 1; we = 1; end
            6: begin rwe = 1; dst = (m_kind == K_R); m2r = (m_kind == K_LW); end
            default: ;
        endcase
        return {alu, a, b, iord_e, req, we, irw, pcw, rwe, dst, m2r,
                m_illegal | m_bus, m_illegal, m_bus, 3'(m_state)};
    endfunction

    logic [22:0] dut_pack;
    assign dut_pack = {ALU_Ctrl, alu_src_a, alu_src_b, iord, mem_req, mem_we, ir_we, pc_we,
                       reg_we, reg_dst, mem_to_reg, halted, illegal, bus_err, state};

    // Compare process: outputs checked at every falling edge, then the
    // model consumes the inputs the DUT will sample at the next rising edge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            check("outputs", 64'(dut_pack), 64'(expected_outputs()));
`ifdef MULTICYCLE_CTRL_PERF_EN
            check("cycle_cnt", 64'(cycle_cnt), 64'(m_cycles));
            check("instret_cnt", 64'(instret_cnt), 64'(m_inst));
`endif
            if (!rst) model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic mr);
        @(posedge clk); #1;
        run = r; mem_ready = mr; opcode = op_s; funct = fn_s;
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; run = 0; mem_ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk); #1;
    endtask

    typedef struct { logic [5:0] op; logic [5:0] fn; logic [5:0] alu; } vec_t;
    vec_t vecs[6];

    initial begin
        vecs[0] = '{6'h00, 6'h22, 6'h22};
        vecs[1] = '{6'h00, 6'h24, 6'h24};
        vecs[2] = '{6'h08, 6'h22, 6'h20};
        vecs[3] = '{6'h00, 6'h25, 6'h25};
        vecs[4] = '{6'h00, 6'h26, 6'h26};
        vecs[5] = '{6'h00, 6'h27, 6'h27};

        #1 rst = 1;
        @(negedge clk); #1;
        check("rst_state", state, 3'd0);
        check("rst_alu_ctrl", ALU_Ctrl, 6'h20);
        check("rst_alu_src_b", alu_src_b, 2'b00);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk); #1;

        // R-type add, zero wait
        op_s = 6'h00; fn_s = 6'h20;
        cyc(1, 1); check("add_idle", state, 3'd0);
        cyc(1, 1); check("add_fetch", state, 3'd1); check("add_ir_we", ir_we, 1'b1);
        check("add_pc_we", pc_we, 1'b1);
        cyc(1, 1); check("add_decode", state, 3'd2);
        cyc(1, 1); check("add_exec", state, 3'd3); check("add_alu", ALU_Ctrl, 6'h20);
        check("add_src_a", alu_src_a, 1'b1);
        cyc(1, 1); check("add_wb", state, 3'd6); check("add_reg_we", reg_we, 1'b1);
        check("add_reg_dst", reg_dst, 1'b1);
        cyc(0, 0); check("add_refetch", state, 3'd1);
        do_reset();

        // lw with two wait cycles on fetch and on read
        op_s = 6'h23; fn_s = 6'h00;
        cyc(1, 0);
        cyc(1, 0); check("lw_f1_ir_we", ir_we, 1'b0);
        cyc(1, 0); check("lw_f2_state", state, 3'd1);
        cyc(1, 1); check("lw_f3_ir_we", ir_we, 1'b1); check("lw_f3_pc_we", pc_we, 1'b1);
        cyc(1, 0); check("lw_decode", state, 3'd2);
        cyc(1, 0); check("lw_exec_src_b", alu_src_b, 2'b10);
        cyc(1, 0); check("lw_memrd", state, 3'd4); check("lw_iord", iord, 1'b1);
        cyc(1, 0);
        cyc(1, 1);
        cyc(0, 0); check("lw_wb", state, 3'd6); check("lw_m2r", mem_to_reg, 1'b1);
        check("lw_reg_dst", reg_dst, 1'b0);
        cyc(0, 0); check("lw_idle", state, 3'd0);

        // sw, zero wait
        op_s = 6'h2b;
        cyc(1, 1);
        cyc(1, 1);
        cyc(1, 1);
        cyc(1, 1);
        cyc(0, 1); check("sw_memwr", state, 3'd5); check("sw_mem_we", mem_we, 1'b1);
        check("sw_iord", iord, 1'b1);
        cyc(0, 0); check("sw_idle", state, 3'd0);

        // sw aborted by reset in MEMWR: no write strobe while rst is high
        cyc(1, 1);
        cyc(1, 1);
        cyc(1, 1);
        cyc(1, 1);
        cyc(1, 0); check("abort_pre", state, 3'd5);
        @(posedge clk); #1;
        rst = 1; mem_ready = 1;
        @(negedge clk); #1;
        check("abort_mem_we", mem_we, 1'b0);
        check("abort_state", state, 3'd0);
        @(posedge clk); #1;
        rst = 0; run = 0; mem_ready = 0;
        @(negedge clk); #1;

        // back-to-back ALU operations
        cyc(1, 1);
        foreach (vecs[i]) begin
            op_s = vecs[i].op; fn_s = vecs[i].fn;
            cyc(1, 1);
            cyc(1, 1);
            cyc(1, 1); check("vec_alu", ALU_Ctrl, vecs[i].alu);
            cyc(1, 1);
        end
        do_reset();

        // illegal funct
        op_s = 6'h00; fn_s = 6'h2a;
        cyc(1, 1);
        cyc(1, 1);
        cyc(1, 1); check("ill_decode_flag", illegal, 1'b0);
        cyc(1, 1); check("ill_state", state, 3'd7); check("ill_flag", illegal, 1'b1);
        check("ill_halted", halted, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1, 1'(i & 1));
        check("ill_still_halt", state, 3'd7);
        do_reset();
        check("ill_cleared", illegal, 1'b0);
        check("ill_halt_cleared", halted, 1'b0);

        // fetch timeout after 16 request cycles
        op_s = 6'h00; fn_s = 6'h20;
        cyc(1, 0);
        for (int k = 1; k <= 16; k++) cyc(1, 0);
        check("to_16th_state", state, 3'd1);
        check("to_16th_bus_err", bus_err, 1'b0);
        cyc(1, 0); check("to_halt", state, 3'd7); check("to_bus_err", bus_err, 1'b1);
        check("to_halted", halted, 1'b1);
        do_reset();

        // mem_ready in exactly the 16th fetch cycle wins
        cyc(1, 0);
        for (int k = 1; k <= 15; k++) cyc(1, 0);
        cyc(1, 1);
        cyc(1, 0); check("late_ready_state", state, 3'd2);
        check("late_ready_bus_err", bus_err, 1'b0);
        do_reset();

        // addi with run dropped during EXEC
        op_s = 6'h08; fn_s = 6'h00;
        cyc(1, 1);
        cyc(1, 1);
        cyc(1, 1);
        cyc(0, 1); check("addi_exec_src_b", alu_src_b, 2'b10);
        cyc(0, 1); check("addi_wb", state, 3'd6); check("addi_reg_dst", reg_dst, 1'b0);
        cyc(0, 0); check("addi_idle", state, 3'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("perf_instret", instret_cnt, 1);
        check("perf_cycles", cycle_cnt, 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
